// File: rtl/wb_data_ram_slave.sv
// Wishbone-style data RAM shared by several j1 cores: a round-robin arbiter picks one
// requester, performs a single-word access after WAIT_STATES cycles and pulses that master's ack.
module wb_data_ram_slave #(
  parameter int NUM_CPU     = 4,
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CPU-1:0]         cyc_i,
  input  logic [NUM_CPU-1:0]         we_i,
  input  logic [NUM_CPU*ADDR_W-1:0]  adr_i,
  input  logic [NUM_CPU*DATA_W-1:0]  dat_i,
  output logic [DATA_W-1:0]          dat_o,
  output logic [NUM_CPU-1:0]         ack_o,
  output logic                       busy_o,
  output logic [2:0]                 grant_o
);

  localparam int PTR_W = (NUM_CPU > 1) ? $clog2(NUM_CPU) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [PTR_W-1:0]      grant_q, grant_d;
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     adr_q, adr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [NUM_CPU-1:0]    ack_q, ack_d;
  logic                  busy_q, busy_d;
  logic                  mem_we_s;
  logic                  pick_valid_s;
  logic [PTR_W-1:0]      pick_idx_s;
  logic [PTR_W-1:0]      idx_s;
  logic [DATA_W-1:0]     mem_q [2**ADDR_W];

  // Round-robin search: first requester at or above rr_ptr, wrapping around.
  always_comb begin
    pick_valid_s = 1'b0;
    pick_idx_s   = '0;
    idx_s        = '0;
    for (int i = 0; i < NUM_CPU; i++) begin
      idx_s = PTR_W'((int'(rr_ptr_q) + i) % NUM_CPU);
      if (!pick_valid_s && cyc_i[idx_s]) begin
        pick_valid_s = 1'b1;
        pick_idx_s   = idx_s;
      end else begin
        pick_valid_s = pick_valid_s;
      end
    end
  end

  // Transaction FSM next-state and registered-output values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    we_d     = we_q;
    adr_d    = adr_q;
    wdata_d  = wdata_q;
    data_d   = data_q;
    ack_d    = '0;
    mem_we_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_valid_s) begin
          grant_d = pick_idx_s;
          we_d    = we_i[pick_idx_s];
          adr_d   = adr_i[int'(pick_idx_s)*ADDR_W +: ADDR_W];
          wdata_d = dat_i[int'(pick_idx_s)*DATA_W +: DATA_W];
          cnt_d   = 4'(WAIT_STATES);
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          mem_we_s = we_q;
          data_d   = we_q ? '0 : mem_q[adr_q];
          ack_d    = NUM_CPU'(1) << grant_q;
          state_d  = S_ACK;
        end
      end
      S_ACK: begin
        // data is cleared on the way out so dat_o stays zero whenever no ack is shown
        data_d   = '0;
        rr_ptr_d = (grant_q == PTR_W'(NUM_CPU - 1)) ? '0 : grant_q + PTR_W'(1);
        state_d  = S_IDLE;
      end
      default: begin
        data_d  = '0;
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      wdata_q  <= '0;
      data_q   <= '0;
      ack_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      wdata_q  <= wdata_d;
      data_q   <= data_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
    end
  end

  // RAM array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[adr_q] <= wdata_q;
    end
  end

  assign dat_o   = data_q;
  assign ack_o   = ack_q;
  assign busy_o  = busy_q;
  assign grant_o = 3'(grant_q);

endmodule
